// File: rtl/param_memory.sv
// Parametrised word-addressed data memory with per-byte write lanes, configurable
// read/write latency and a busy/valid completion handshake; rejected accesses raise error.
module param_memory #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    DEPTH         = 262144,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = 32'h8002_0000,
  parameter int                    READ_LATENCY  = 2,
  parameter int                    WRITE_LATENCY = 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  input  logic                    read_write,
  input  logic                    enable,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    busy,
  output logic                    valid,
  output logic                    error
);

  localparam int BYTES   = DATA_WIDTH / 8;
  localparam int LSB     = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [CNT_W-1:0]    READ_LOAD  = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0]    WRITE_LOAD = CNT_W'(WRITE_LATENCY - 1);
  localparam logic [ADDR_WIDTH:0] LANE_MASK  = (ADDR_WIDTH + 1)'((1 << LSB) - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT  = (ADDR_WIDTH + 1)'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_count;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [BYTES-1:0]      r_be;
  logic                  r_read;
  logic [DATA_WIDTH-1:0] r_dataOut;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_complete;
  logic [ADDR_WIDTH:0]   w_index;
  logic                  w_below;
  logic                  w_beyond;
  logic                  w_misaligned;
  logic                  w_err;
  logic [IDX_W-1:0]      w_idx;

  assign w_accept   = enable && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_complete = (r_state == S_WAIT) && (r_count == '0);

  // One extra bit so an address just below a base near the top of the space
  // cannot wrap into a small, apparently valid index.
  assign w_below      = {1'b0, r_addr} < {1'b0, BASE_ADDR};
  assign w_index      = ({1'b0, r_addr} - {1'b0, BASE_ADDR}) >> LSB;
  assign w_beyond     = w_index >= DEPTH_EXT;
  assign w_misaligned = |({1'b0, r_addr} & LANE_MASK);
  assign w_err        = w_below || w_beyond || w_misaligned;
  assign w_idx        = w_index[IDX_W-1:0];

  // WAIT is always entered, even for a latency of one, so that completion
  // lands on edge N+LATENCY and DONE follows it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_read  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_addr  <= address;
            r_wdata <= data_in;
            r_be    <= byte_en;
            r_read  <= read_write;
            r_count <= read_write ? READ_LOAD : WRITE_LOAD;
            r_state <= S_WAIT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (r_count == '0) begin
            r_state <= S_DONE;
          end else begin
            r_count <= r_count - CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_dataOut <= '0;
    end else if (w_complete && r_read && !w_err) begin
      r_dataOut <= r_mem[w_idx];
    end else begin
      r_dataOut <= '0;
    end
  end

  // Array is deliberately left without reset; a write aborted by reset never
  // reaches its completion edge because the state machine is already IDLE.
  always_ff @(posedge clock) begin
    if (w_complete && !r_read && !w_err) begin
      for (int i = 0; i < BYTES; i++) begin
        if (r_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  assign data_out = r_dataOut;
  assign busy     = (r_state == S_WAIT);
  assign valid    = (r_state == S_DONE);
  assign error    = (r_state == S_DONE) && w_err;

endmodule

// File: tb/tb_param_memory.sv
// Self-checking bench for param_memory: a transaction-level model predicts
// busy/valid/error/data_out every cycle, with directed and randomised requests.
module tb_param_memory;

  localparam logic [31:0] BASE   = 32'h8002_0000;
  localparam int          DEPTH  = 262144;
  localparam int          RD_LAT = 2;
  localparam int          WR_LAT = 1;

  logic        clock;
  logic        reset_n;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [3:0]  byte_en;
  logic        read_write;
  logic        enable;
  logic [31:0] data_out;
  logic        busy;
  logic        valid;
  logic        error;

  logic [31:0] wAddress;
  logic        wEnable;
  logic [31:0] wDataOut;
  logic        wBusy;
  logic        wValid;
  logic        wError;

  int checks   = 0;
  int failures = 0;

  param_memory #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .BASE_ADDR(BASE),
    .READ_LATENCY(RD_LAT), .WRITE_LATENCY(WR_LAT)
  ) dut (
    .clock(clock), .reset_n(reset_n), .address(address), .data_in(data_in),
    .byte_en(byte_en), .read_write(read_write), .enable(enable),
    .data_out(data_out), .busy(busy), .valid(valid), .error(error)
  );

  param_memory #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(8), .BASE_ADDR(32'hFFFF_FFF0),
    .READ_LATENCY(2), .WRITE_LATENCY(1)
  ) dutWrap (
    .clock(clock), .reset_n(reset_n), .address(wAddress), .data_in(32'h0),
    .byte_en(4'h0), .read_write(1'b1), .enable(wEnable),
    .data_out(wDataOut), .busy(wBusy), .valid(wValid), .error(wError)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: memory contents as a sparse word map, plus one pending
  // transaction described by its acceptance outcome and completion edge.
  logic [31:0] modelMem [int unsigned];
  int          edgeNo   = 0;
  bit          pend     = 0;
  int          doneEdge = 0;
  bit          pRead    = 0;
  bit          pErr     = 0;
  logic [31:0] pAddr    = '0;
  logic [31:0] pData    = '0;
  logic [31:0] pWord    = '0;
  logic [3:0]  pBe      = '0;
  logic [31:0] tmpWord  = '0;
  logic        expBusy  = 1'b0;
  logic        expValid = 1'b0;
  logic        expError = 1'b0;
  logic [31:0] expData  = '0;
  bit          cmpOn    = 0;

  function automatic bit addrBad(input logic [31:0] a);
    longint la = longint'(a);
    longint lb = longint'(BASE);
    if (la < lb) return 1'b1;
    if ((la - lb) / 4 >= longint'(DEPTH)) return 1'b1;
    return (la % 4) != 0;
  endfunction

  function automatic int unsigned wordOf(input logic [31:0] a);
    return (a - BASE) / 4;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend     = 0;
      expBusy  = 1'b0;
      expValid = 1'b0;
      expError = 1'b0;
      expData  = '0;
    end else begin
      edgeNo++;
      if (pend && edgeNo == doneEdge && !pErr) begin
        if (modelMem.exists(wordOf(pAddr))) tmpWord = modelMem[wordOf(pAddr)];
        else tmpWord = '0;
        if (pRead) begin
          pWord = tmpWord;
        end else begin
          for (int i = 0; i < 4; i++)
            if (pBe[i]) tmpWord[8*i +: 8] = pData[8*i +: 8];
          modelMem[wordOf(pAddr)] = tmpWord;
        end
      end
      if (enable && (!pend || edgeNo == doneEdge + 1)) begin
        pend     = 1;
        pRead    = read_write;
        pAddr    = address;
        pData    = data_in;
        pBe      = byte_en;
        pErr     = addrBad(address);
        doneEdge = edgeNo + (read_write ? RD_LAT : WR_LAT);
      end else if (pend && edgeNo > doneEdge) begin
        pend = 0;
      end
      expBusy  = pend && edgeNo < doneEdge;
      expValid = pend && edgeNo == doneEdge;
      expError = expValid && pErr;
      expData  = (expValid && pRead && !pErr) ? pWord : '0;
    end
  end

  always @(negedge clock) begin
    if (cmpOn) begin
      checkOutput("busy", busy, expBusy);
      checkOutput("valid", valid, expValid);
      checkOutput("error", error, expError);
      checkOutput("data_out", data_out, expData);
    end
  end

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                               input logic rw, output logic [31:0] rData, output logic rErr, output int lat);
    bit seen = 0;
    @(negedge clock);
    address    = addr;
    data_in    = data;
    byte_en    = be;
    read_write = rw;
    enable     = 1'b1;
    @(posedge clock);
    @(negedge clock);
    enable = 1'b0;
    rData  = '0;
    rErr   = 1'b0;
    lat    = -1;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (i > 0) @(negedge clock);
      if (valid === 1'b1) begin
        seen  = 1;
        lat   = i;
        rData = data_out;
        rErr  = error;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL timeout: no valid within 20 cycles for address %h", addr);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        re;
    int          lat;
    int          cnt;
    logic [31:0] mask;
    logic [31:0] pool [12];
    logic [31:0] wrapAddrs [5];
    logic        wrapErrs [5];
    logic [31:0] a;

    reset_n = 1'b0; enable = 1'b0; address = '0; data_in = '0; byte_en = '0; read_write = 1'b1;
    wEnable = 1'b0; wAddress = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    cmpOn = 1;
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetValid", valid, 0);
    checkOutput("resetError", error, 0);
    checkOutput("resetData", data_out, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;

    // Write, then abort a read of the same word with reset; contents survive.
    applyStimulus(32'h8002_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, rd, re, lat);
    checkOutput("writeLatency", lat, 1);
    checkOutput("writeData", rd, 0);
    @(negedge clock);
    address = 32'h8002_0010; read_write = 1'b1; enable = 1'b1;
    @(posedge clock);
    @(negedge clock);
    enable = 1'b0;
    checkOutput("midBusy", busy, 1);
    @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstValid", valid, 0);
    checkOutput("rstData", data_out, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    applyStimulus(32'h8002_0010, 32'h0, 4'h0, 1'b1, rd, re, lat);
    checkOutput("reread", rd, 32'hDEAD_BEEF);
    checkOutput("rereadLatency", lat, 2);

    // Byte lanes.
    applyStimulus(BASE, 32'h1122_3344, 4'hF, 1'b0, rd, re, lat);
    applyStimulus(BASE, 32'hAABB_CCDD, 4'h5, 1'b0, rd, re, lat);
    applyStimulus(BASE, 32'h0, 4'h0, 1'b1, rd, re, lat);
    checkOutput("laneMerge", rd, 32'h11BB_33DD);
    checkOutput("laneErr", re, 0);

    // Cycle-by-cycle handshake of a default-latency read.
    @(negedge clock);
    address = BASE; read_write = 1'b1; enable = 1'b1;
    @(posedge clock);
    @(negedge clock);
    enable = 1'b0;
    checkOutput("latBusyN", busy, 1);
    checkOutput("latValidN", valid, 0);
    @(negedge clock);
    checkOutput("latBusyN1", busy, 1);
    checkOutput("latValidN1", valid, 0);
    @(negedge clock);
    checkOutput("latBusyN2", busy, 0);
    checkOutput("latValidN2", valid, 1);
    checkOutput("latDataN2", data_out, 32'h11BB_33DD);
    @(negedge clock);
    checkOutput("latValidN3", valid, 0);
    checkOutput("latDataN3", data_out, 0);

    // Rejected accesses.
    applyStimulus(32'h8001_FFFC, 32'h0, 4'h0, 1'b1, rd, re, lat);
    checkOutput("belowErr", re, 1);
    checkOutput("belowData", rd, 0);
    checkOutput("belowLat", lat, 2);
    applyStimulus(32'h8002_0002, 32'h0, 4'h0, 1'b1, rd, re, lat);
    checkOutput("misalignErr", re, 1);
    checkOutput("misalignData", rd, 0);
    applyStimulus(32'h8012_0000, 32'hFFFF_FFFF, 4'hF, 1'b0, rd, re, lat);
    checkOutput("beyondErr", re, 1);
    checkOutput("beyondLat", lat, 1);
    applyStimulus(BASE, 32'h0, 4'h0, 1'b1, rd, re, lat);
    checkOutput("neighbourKept", rd, 32'h11BB_33DD);
    applyStimulus(32'h8011_FFFC, 32'h5A5A_0FF0, 4'hF, 1'b0, rd, re, lat);
    checkOutput("lastWordErr", re, 0);

    // Enable held high: accepts every LATENCY+1 cycles, ignored while busy.
    @(negedge clock);
    address = BASE; read_write = 1'b1; enable = 1'b1;
    @(posedge clock);
    cnt = 0;
    mask = '0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clock);
      if (valid === 1'b1) begin
        cnt++;
        mask[i] = 1'b1;
      end
      if (i == 6) enable = 1'b0;
    end
    checkOutput("b2bCount", cnt, 3);
    checkOutput("b2bSlots", mask, 32'h0000_0124);

    // Base near the top of the address space.
    wrapAddrs = '{32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFC, 32'hFFFF_FFF2, 32'hFFFF_FFEC};
    wrapErrs  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      wAddress = wrapAddrs[k];
      wEnable  = 1'b1;
      @(posedge clock);
      @(negedge clock);
      wEnable = 1'b0;
      @(negedge clock);
      @(negedge clock);
      checkOutput($sformatf("wrapValid%0d", k), wValid, 1);
      checkOutput($sformatf("wrapError%0d", k), wError, wrapErrs[k]);
      if (wrapErrs[k]) checkOutput($sformatf("wrapData%0d", k), wDataOut, 0);
    end

    // Randomised traffic over low and top-of-array words plus bad addresses.
    for (int i = 0; i < 12; i++) begin
      pool[i] = (i < 8) ? BASE + 32'(4 * i) : BASE + 32'(4 * (DEPTH - 12 + i));
      applyStimulus(pool[i], $urandom, 4'hF, 1'b0, rd, re, lat);
    end
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: a = BASE - 32'd4;
          1: a = BASE + 32'(4 * DEPTH);
          2: a = BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(1, 3));
          default: a = 32'h0000_0000;
        endcase
      end else begin
        a = pool[$urandom_range(0, 11)];
      end
      applyStimulus(a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), rd, re, lat);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
